// File: rtl/dist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dist_pkg
// Description : Shared types, constants and helper functions for the
//               distribution sample generator (xorshift32 step, leading-zero
//               count, channel index width).
// Revision    : 1.0 - initial release
// ============================================================================
package dist_pkg;

    typedef enum logic [1:0] {
        MODE_UNIFORM     = 2'd0,
        MODE_NORMAL      = 2'd1,
        MODE_EXPONENTIAL = 2'd2,
        MODE_BERNOULLI   = 2'd3
    } dist_mode_e;

    // Spreads reset seeds across channels so lanes start decorrelated.
    localparam logic [31:0] XS_SEED_SPREAD = 32'h9E37_79B9;
    // xorshift32 locks up at zero, so a zero seed is replaced by this value.
    localparam logic [31:0] XS_ZERO_SUB    = 32'h2545_F491;

    // Width of a channel index; never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One xorshift32 step: x ^= x<<13; x ^= x>>17; x ^= x<<5.
    function automatic logic [31:0] xorshift32_step(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    // Count of leading zeros, 0..32.
    function automatic logic [5:0] lzc32(input logic [31:0] x);
        logic [5:0] n;
        logic       found;
        n     = 6'd0;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found) begin
                if (x[i]) begin
                    found = 1'b1;
                end else begin
                    n = n + 6'd1;
                end
            end
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xorshift32_lane.sv
`default_nettype none
// ============================================================================
// Module      : xorshift32_lane
// Description : One xorshift32 generator channel. Holds the 32-bit state,
//               advances it on a draw and accepts a seed write. The next
//               state is exported so the caller can shape the drawn value in
//               the same cycle the lane advances.
// Revision    : 1.0 - initial release
// ============================================================================
module xorshift32_lane
    import dist_pkg::*;
#(
    parameter logic [31:0] RESET_SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_draw,
    input  logic        i_seed_load,
    input  logic [31:0] i_seed,
    output logic [31:0] o_next
);

    logic [31:0] r_state;
    logic [31:0] w_seed_val;

    assign w_seed_val = (i_seed == 32'd0) ? XS_ZERO_SUB : i_seed;
    assign o_next     = xorshift32_step(r_state);

    // Generator state; a seed write wins over a simultaneous draw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RESET_SEED;
        end else if (i_seed_load) begin
            r_state <= w_seed_val;
        end else if (i_draw) begin
            r_state <= o_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dist_sample_gen.sv
`default_nettype none
// ============================================================================
// Module      : dist_sample_gen
// Description : Multi-channel xorshift32 sample generator. Channels are drawn
//               round-robin and each draw is shaped into a uniform,
//               approx-normal, geometric-exponential or Bernoulli sample,
//               delivered on a valid/ready stream tagged with the channel.
// Revision    : 1.0 - initial release
// ============================================================================
module dist_sample_gen
    import dist_pkg::*;
#(
    parameter int          NUM_CH       = 2,
    parameter int          NORM_TERMS   = 4,
    parameter logic [31:0] DEFAULT_SEED = 32'h0000_0001
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [1:0]                    mode_in,
    input  logic [31:0]                   param1_in,
    input  logic [31:0]                   param2_in,
    input  logic                          seed_load,
    input  logic [ch_width(NUM_CH)-1:0]   seed_ch,
    input  logic [31:0]                   seed_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_data,
    output logic [ch_width(NUM_CH)-1:0]   out_ch,
    output logic                          busy
);

    localparam int c_CH_W   = ch_width(NUM_CH);
    localparam int c_TERM_W = $clog2(NORM_TERMS);
    localparam int c_ACC_W  = 16 + c_TERM_W;

    localparam logic [c_CH_W-1:0]          c_LAST_CH   = c_CH_W'(NUM_CH - 1);
    localparam logic [c_TERM_W-1:0]        c_LAST_TERM = c_TERM_W'(NORM_TERMS - 1);
    // Mean of the summed 16-bit terms, removed to centre the normal sample.
    localparam logic signed [c_ACC_W:0]    c_NORM_BIAS = (c_ACC_W + 1)'(NORM_TERMS * 32768);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_DRAW = 2'd1;
    localparam logic [1:0] c_S_HOLD = 2'd2;

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    dist_mode_e              r_mode;
    logic [31:0]             r_p1;
    logic [31:0]             r_p2;
    logic [c_CH_W-1:0]       r_ch;
    logic [c_ACC_W-1:0]      r_acc;
    logic [c_TERM_W-1:0]     r_term;
    logic [31:0]             r_out_data;
    logic [c_CH_W-1:0]       r_out_ch;

    logic                    w_start;
    logic                    w_draw_act;
    logic                    w_last_draw;
    logic                    w_capture;
    logic                    w_abort;
    logic                    w_accept;
    logic                    w_seed_hit;
    logic [NUM_CH-1:0]       w_lane_seed;
    logic [31:0]             w_lane_next [NUM_CH];
    logic [31:0]             w_r;
    logic [31:0]             w_sample;

    // ------------------------------------------------------------------
    // Generator lanes
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        localparam logic [31:0] c_LANE_SEED = DEFAULT_SEED ^ (32'(g) * XS_SEED_SPREAD);

        assign w_lane_seed[g] = seed_load && (seed_ch == c_CH_W'(g));

        xorshift32_lane #(
            .RESET_SEED (c_LANE_SEED)
        ) u_lane (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_draw      (w_draw_act && (r_ch == c_CH_W'(g))),
            .i_seed_load (w_lane_seed[g]),
            .i_seed      (seed_in),
            .o_next      (w_lane_next[g])
        );
    end

    // A seed aimed at a channel that does not exist decodes to no lane.
    assign w_seed_hit = |w_lane_seed;
    assign w_r        = w_lane_next[r_ch];

    // ------------------------------------------------------------------
    // Shaping
    // ------------------------------------------------------------------
    logic [31:0]             w_lo;
    logic [31:0]             w_hi;
    logic [32:0]             w_span;
    logic [63:0]             w_uprod;
    logic [31:0]             w_uniform;
    logic [c_ACC_W-1:0]      w_acc_sum;
    logic signed [c_ACC_W:0] w_centered;
    logic signed [63:0]      w_nprod;
    logic signed [63:0]      w_nshift;
    logic [31:0]             w_normal;
    logic [5:0]              w_lzc;
    logic [31:0]             w_expo;
    logic [31:0]             w_bern;
    logic                    w_unused;

    assign w_lo   = ($signed(r_p1) <= $signed(r_p2)) ? r_p1 : r_p2;
    assign w_hi   = ($signed(r_p1) <= $signed(r_p2)) ? r_p2 : r_p1;
    // hi >= lo, so the 33-bit difference is non-negative; span is 1..2^32.
    assign w_span = {w_hi[31], w_hi} - {w_lo[31], w_lo} + 33'd1;
    assign w_uprod = {32'd0, w_r} * {32'd0, w_span[31:0]};
    // A full 2^32 span is the raw draw itself.
    assign w_uniform = w_span[32] ? w_r : (w_lo + w_uprod[63:32]);

    assign w_acc_sum  = r_acc + c_ACC_W'(w_r[31:16]);
    assign w_centered = $signed({1'b0, w_acc_sum}) - c_NORM_BIAS;
    assign w_nprod    = 64'(w_centered) * 64'($signed(r_p2));
    assign w_nshift   = w_nprod >>> 14;
    assign w_normal   = r_p1 + w_nshift[31:0];

    assign w_lzc  = lzc32(w_r);
    assign w_expo = 32'(w_lzc) * r_p1;

    assign w_bern = ($signed({16'd0, w_r[31:16]}) < $signed(r_p1)) ? 32'd1 : 32'd0;

    assign w_unused = ^{w_uprod[31:0], w_nshift[63:32]};

    // Select the shaped sample for the latched mode.
    always_comb begin
        w_sample = w_uniform;
        case (r_mode)
            MODE_UNIFORM:     w_sample = w_uniform;
            MODE_NORMAL:      w_sample = w_normal;
            MODE_EXPONENTIAL: w_sample = w_expo;
            MODE_BERNOULLI:   w_sample = w_bern;
            default:          w_sample = w_uniform;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    assign w_last_draw = (r_mode != MODE_NORMAL) || (r_term == c_LAST_TERM);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: a valid seed write during DRAW aborts the sample.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (en && !out_valid) begin
                    w_state_nxt = c_S_DRAW;
                end
            end
            c_S_DRAW: begin
                if (w_seed_hit) begin
                    w_state_nxt = c_S_IDLE;
                end else if (w_last_draw) begin
                    w_state_nxt = c_S_HOLD;
                end
            end
            c_S_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    // FSM outputs and datapath strobes.
    always_comb begin
        out_valid  = (r_state == c_S_HOLD);
        busy       = (r_state != c_S_IDLE);
        w_start    = (r_state == c_S_IDLE) && en;
        w_draw_act = (r_state == c_S_DRAW);
        w_abort    = (r_state == c_S_DRAW) && w_seed_hit;
        w_capture  = (r_state == c_S_DRAW) && w_last_draw && !w_seed_hit;
        w_accept   = (r_state == c_S_HOLD) && out_ready;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------

    // Latch the sample configuration when a sample starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= MODE_UNIFORM;
            r_p1   <= 32'd0;
            r_p2   <= 32'd0;
        end else if (w_start) begin
            r_mode <= dist_mode_e'(mode_in);
            r_p1   <= param1_in;
            r_p2   <= param2_in;
        end
    end

    // Normal-mode accumulator; cleared at completion or abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_term <= '0;
        end else if (w_abort || w_capture) begin
            r_acc  <= '0;
            r_term <= '0;
        end else if (w_draw_act && (r_mode == MODE_NORMAL)) begin
            r_acc  <= w_acc_sum;
            r_term <= r_term + c_TERM_W'(1);
        end
    end

    // Round-robin channel pointer, advanced only when a sample is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch <= '0;
        end else if (w_accept) begin
            r_ch <= (r_ch == c_LAST_CH) ? '0 : (r_ch + c_CH_W'(1));
        end
    end

    // Output register, loaded when a sample completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data <= 32'd0;
            r_out_ch   <= '0;
        end else if (w_capture) begin
            r_out_data <= w_sample;
            r_out_ch   <= r_ch;
        end
    end

    assign out_data = r_out_data;
    assign out_ch   = r_out_ch;

endmodule
`default_nettype wire
